// File: rtl/npu_network_defines.sv
// Shared mesh-network types: flit layout, flit kinds, output port encoding.
package npu_network_defines;

    localparam int TOT_X_NODE_W = 2;
    localparam int TOT_Y_NODE_W = 2;
    localparam int PAYLOAD_W    = 16;
    localparam int PORT_NUM_W   = 3;

    typedef enum logic [1:0] {HEADER, BODY, TAIL, HT} flit_type_t;

    typedef enum logic [PORT_NUM_W-1:0] {LOCAL, EAST, WEST, NORTH, SOUTH} port_t;

    typedef struct packed {
        logic [TOT_X_NODE_W-1:0] x;
        logic [TOT_Y_NODE_W-1:0] y;
    } coord_t;

    typedef struct packed {
        flit_type_t           flit_type;
        coord_t               destination;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

endpackage

// File: rtl/routing_xy.sv
// Dimension-ordered XY routing: resolve X first, then Y (y grows southwards).
module routing_xy
    import npu_network_defines::*;
#(
    parameter int MY_X_ADDR = 0,
    parameter int MY_Y_ADDR = 0
) (
    input  logic [TOT_X_NODE_W-1:0] dest_x,
    input  logic [TOT_Y_NODE_W-1:0] dest_y,
    output port_t                   port
);

    localparam logic [TOT_X_NODE_W-1:0] MY_X = TOT_X_NODE_W'(MY_X_ADDR);
    localparam logic [TOT_Y_NODE_W-1:0] MY_Y = TOT_Y_NODE_W'(MY_Y_ADDR);

    // NOTE: default assignment first so every path drives port and no latch is inferred.
    always_comb begin
        port = LOCAL;
        if (dest_x > MY_X)      port = EAST;
        else if (dest_x < MY_X) port = WEST;
        else if (dest_y > MY_Y) port = SOUTH;
        else if (dest_y < MY_Y) port = NORTH;
    end

endmodule

// File: rtl/sync_fifo_flit.sv
// Single-clock flit FIFO; a write on a full FIFO is accepted only alongside a pop.
module sync_fifo_flit
    import npu_network_defines::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  flit_t                    data_in,
    input  logic                     pop,
    output flit_t                    data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    flit_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop_ok;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign occupancy = count;
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign data_out  = mem[rd_ptr];

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/router_input_unit.sv
// Single-VC router input port: flit buffer, on/off back-pressure, per-packet
// route latch and switch-allocator request interface.
module router_input_unit
    import npu_network_defines::*;
#(
    parameter int MY_X_ADDR  = 0,
    parameter int MY_Y_ADDR  = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int ON_OFF_LAT = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  flit_in_valid,
    input  flit_t flit_in,
    output logic  on_off_out,
    output logic  sa_request,
    output port_t sa_port,
    output flit_t flit_out,
    input  logic  sa_grant,
    output logic  proto_error
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] ON_THRESH = OCC_W'(FIFO_DEPTH - ON_OFF_LAT);

    typedef enum logic {IDLE, ROUTED} state_t;

    state_t           state;
    logic             first_pending;
    flit_t            head;
    logic             full;
    logic             empty;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    port_t            route;
    logic             head_is_start;
    logic             head_is_end;
    logic             pop;
    logic             push_ok;

    sync_fifo_flit #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (flit_in_valid),
        .data_in   (flit_in),
        .pop       (pop),
        .data_out  (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occ)
    );

    routing_xy #(.MY_X_ADDR(MY_X_ADDR), .MY_Y_ADDR(MY_Y_ADDR)) u_routing (
        .dest_x (head.destination.x),
        .dest_y (head.destination.y),
        .port   (route)
    );

    assign head_is_start = (head.flit_type == HEADER) || (head.flit_type == HT);
    assign head_is_end   = (head.flit_type == TAIL)   || (head.flit_type == HT);
    assign sa_request    = (state == ROUTED) && !empty;
    assign flit_out      = head;

    // Stray BODY/TAIL at the head while idle is discarded without a request.
    assign pop      = ((state == IDLE) && !empty && !head_is_start) || (sa_request && sa_grant);
    assign push_ok  = flit_in_valid && (!full || pop);
    assign occ_next = occ + OCC_W'(push_ok) - OCC_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            first_pending <= 1'b0;
            sa_port       <= LOCAL;
            on_off_out    <= 1'b0;
            proto_error   <= 1'b0;
        end else begin
            on_off_out <= (occ_next >= ON_THRESH);
            if (flit_in_valid && full && !pop) proto_error <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_is_start) begin
                            sa_port       <= route;
                            first_pending <= 1'b1;
                            state         <= ROUTED;
                        end else begin
                            proto_error <= 1'b1;
                        end
                    end
                end
                ROUTED: begin
                    // A new header after the routed one means a missing tail; keep the route.
                    if (!empty && head_is_start && !first_pending) proto_error <= 1'b1;
                    if (pop) begin
                        first_pending <= 1'b0;
                        if (head_is_end) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit at router (1,1), depth 8, on/off latency 2.
module tb_router_input_unit;
    import npu_network_defines::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  flit_in_valid;
    flit_t flit_in;
    logic  on_off_out;
    logic  sa_request;
    port_t sa_port;
    flit_t flit_out;
    logic  sa_grant;
    logic  proto_error;

    int total = 0;
    int bad   = 0;
    logic [15:0] seq = '0;

    router_input_unit #(
        .MY_X_ADDR  (1),
        .MY_Y_ADDR  (1),
        .FIFO_DEPTH (8),
        .ON_OFF_LAT (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flit_in_valid (flit_in_valid),
        .flit_in       (flit_in),
        .on_off_out    (on_off_out),
        .sa_request    (sa_request),
        .sa_port       (sa_port),
        .flit_out      (flit_out),
        .sa_grant      (sa_grant),
        .proto_error   (proto_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       valid;
        flit_type_t ftype;
        logic [1:0] dx;
        logic [1:0] dy;
        logic       grant;
        logic       exp_req;
        port_t      exp_port;
        flit_type_t exp_type;
        logic       exp_on;
        logic       exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one clock cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input logic v, input flit_type_t t, input logic [1:0] x,
                         input logic [1:0] y, input logic g);
        flit_in_valid           = v;
        flit_in.flit_type       = t;
        flit_in.destination.x   = x;
        flit_in.destination.y   = y;
        flit_in.payload         = seq;
        seq                     = seq + 16'd1;
        sa_grant                = g;
        @(posedge clk);
        #1;
        flit_in_valid = 1'b0;
        sa_grant      = 1'b0;
    endtask

    task automatic idle(input logic g);
        cycle(1'b0, BODY, 2'd0, 2'd0, g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        flit_in_valid = 1'b0;
        flit_in       = '0;
        sa_grant      = 1'b0;

        //                 v     type    dx     dy     g     req   port   type  on    err
        tbl[0] = '{1'b1, HT,     2'd3, 2'd1, 1'b0, 1'b0, LOCAL, HT,     1'b0, 1'b0};
        tbl[1] = '{1'b0, BODY,   2'd0, 2'd0, 1'b0, 1'b1, EAST,  HT,     1'b0, 1'b0};
        tbl[2] = '{1'b0, BODY,   2'd0, 2'd0, 1'b1, 1'b0, EAST,  HT,     1'b0, 1'b0};
        tbl[3] = '{1'b1, HEADER, 2'd1, 2'd0, 1'b1, 1'b0, EAST,  HT,     1'b0, 1'b0};
        tbl[4] = '{1'b1, BODY,   2'd1, 2'd0, 1'b1, 1'b1, NORTH, HEADER, 1'b0, 1'b0};
        tbl[5] = '{1'b1, BODY,   2'd1, 2'd0, 1'b1, 1'b1, NORTH, BODY,   1'b0, 1'b0};
        tbl[6] = '{1'b1, TAIL,   2'd1, 2'd0, 1'b1, 1'b1, NORTH, BODY,   1'b0, 1'b0};
        tbl[7] = '{1'b0, BODY,   2'd0, 2'd0, 1'b1, 1'b1, NORTH, TAIL,   1'b0, 1'b0};
        tbl[8] = '{1'b0, BODY,   2'd0, 2'd0, 1'b1, 1'b0, NORTH, TAIL,   1'b0, 1'b0};
        tbl[9] = '{1'b0, BODY,   2'd0, 2'd0, 1'b1, 1'b0, NORTH, TAIL,   1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset req",    32'(sa_request),  32'(1'b0));
        check("reset port",   32'(sa_port),     32'(LOCAL));
        check("reset on_off", 32'(on_off_out),  32'(1'b0));
        check("reset err",    32'(proto_error), 32'(1'b0));

        // Single HT packet, then a 4-flit packet with grants held high.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].valid, tbl[i].ftype, tbl[i].dx, tbl[i].dy, tbl[i].grant);
            check($sformatf("vec%0d req", i),    32'(sa_request),  32'(tbl[i].exp_req));
            check($sformatf("vec%0d port", i),   32'(sa_port),     32'(tbl[i].exp_port));
            check($sformatf("vec%0d on_off", i), 32'(on_off_out),  32'(tbl[i].exp_on));
            check($sformatf("vec%0d err", i),    32'(proto_error), 32'(tbl[i].exp_err));
            if (tbl[i].exp_req)
                check($sformatf("vec%0d type", i), 32'(flit_out.flit_type), 32'(tbl[i].exp_type));
        end

        // Fill without grants: back-pressure at 6 entries, overflow on the 9th write.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i == 0) ? HEADER : BODY, 2'd1, 2'd1, 1'b0);
            check($sformatf("fill%0d on_off", i + 1), 32'(on_off_out), 32'((i + 1) >= 6));
            check($sformatf("fill%0d err", i + 1),    32'(proto_error), 32'(1'b0));
        end
        cycle(1'b1, BODY, 2'd1, 2'd1, 1'b0);
        check("overflow err",  32'(proto_error),        32'(1'b1));
        check("overflow req",  32'(sa_request),         32'(1'b1));
        check("overflow port", 32'(sa_port),            32'(LOCAL));
        check("overflow head", 32'(flit_out.flit_type), 32'(HEADER));
        begin
            int pops = 0;
            sa_grant = 1'b1;
            for (int k = 0; k < 20 && sa_request; k++) begin
                @(posedge clk);
                #1;
                pops++;
            end
            sa_grant = 1'b0;
            check("drain pops",   32'(pops),       32'd8);
            check("drain req",    32'(sa_request), 32'(1'b0));
            check("drain on_off", 32'(on_off_out), 32'(1'b0));
        end

        // Stray BODY while idle, then HT to (0,1) routes WEST.
        do_reset();
        check("reset2 err", 32'(proto_error), 32'(1'b0));
        cycle(1'b1, BODY, 2'd2, 2'd2, 1'b0);
        check("stray req0", 32'(sa_request), 32'(1'b0));
        idle(1'b0);
        check("stray req1", 32'(sa_request),  32'(1'b0));
        check("stray err",  32'(proto_error), 32'(1'b1));
        cycle(1'b1, HT, 2'd0, 2'd1, 1'b0);
        check("west wait",  32'(sa_request), 32'(1'b0));
        idle(1'b0);
        check("west req",  32'(sa_request),         32'(1'b1));
        check("west port", 32'(sa_port),            32'(WEST));
        check("west type", 32'(flit_out.flit_type), 32'(HT));
        idle(1'b1);
        check("west done", 32'(sa_request), 32'(1'b0));

        // Back-to-back HT packets: exactly one bubble between requests.
        do_reset();
        cycle(1'b1, HT, 2'd1, 2'd1, 1'b1);
        check("b2b c1 req",  32'(sa_request), 32'(1'b0));
        cycle(1'b1, HT, 2'd1, 2'd2, 1'b1);
        check("b2b c2 req",  32'(sa_request), 32'(1'b1));
        check("b2b c2 port", 32'(sa_port),    32'(LOCAL));
        idle(1'b1);
        check("b2b bubble",  32'(sa_request), 32'(1'b0));
        idle(1'b1);
        check("b2b c4 req",  32'(sa_request), 32'(1'b1));
        check("b2b c4 port", 32'(sa_port),    32'(SOUTH));
        idle(1'b1);
        check("b2b c5 req",  32'(sa_request), 32'(1'b0));

        // Reset after two flits of a 4-flit packet.
        cycle(1'b1, HEADER, 2'd2, 2'd1, 1'b0);
        cycle(1'b1, BODY,   2'd2, 2'd1, 1'b0);
        check("mid req",  32'(sa_request), 32'(1'b1));
        check("mid port", 32'(sa_port),    32'(EAST));
        do_reset();
        check("flush req",    32'(sa_request),  32'(1'b0));
        check("flush port",   32'(sa_port),     32'(LOCAL));
        check("flush on_off", 32'(on_off_out),  32'(1'b0));
        idle(1'b0);
        idle(1'b0);
        check("flush empty", 32'(sa_request),  32'(1'b0));
        check("flush err",   32'(proto_error), 32'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
